// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and decode helpers for the hazard scoreboard unit.
// FSM encodings, TSC opcode/function constants and source-operand decode.
package hazard_scoreboard_unit_pkg;

    typedef enum logic [1:0] {
        HCU_S_RUN   = 2'd0,
        HCU_S_DWAIT = 2'd1,
        HCU_S_HALT  = 2'd2
    } hcu_state_e;

    // Winning cause in the output priority chain; drives controls and perf counters.
    typedef enum logic [2:0] {
        HCU_C_NONE    = 3'd0,
        HCU_C_RESET   = 3'd1,
        HCU_C_HALT    = 3'd2,
        HCU_C_DFREEZE = 3'd3,
        HCU_C_BMISS   = 3'd4,
        HCU_C_JMISS   = 3'd5,
        HCU_C_DSTALL  = 3'd6,
        HCU_C_IFETCH  = 3'd7
    } hcu_cause_e;

    typedef struct packed {
        logic pc_write;
        logic ir_write;
        logic flush_ifid;
        logic flush_idex;
        logic freeze_all;
        logic halted;
    } hcu_ctrl_t;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_SHR = 6'd7;
    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    // R-type arithmetic occupies function codes ADD(0) through SHR(7).
    function automatic logic is_r_arith(input logic [3:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) && (fn <= FN_SHR);
    endfunction

    function automatic logic uses_rs(input logic [3:0] op, input logic [5:0] fn);
        logic r_misc;
        r_misc = (op == OP_RTYPE) && ((fn == FN_WWD) || (fn == FN_JPR) || (fn == FN_JRL));
        return is_r_arith(op, fn) || r_misc ||
               (op == OP_ADI) || (op == OP_ORI) || (op == OP_LWD) || (op == OP_SWD) ||
               (op == OP_BNE) || (op == OP_BEQ) || (op == OP_BGZ) || (op == OP_BLZ);
    endfunction

    function automatic logic uses_rt(input logic [3:0] op, input logic [5:0] fn);
        return is_r_arith(op, fn) || (op == OP_SWD) || (op == OP_BNE) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_scoreboard.sv
// Per-register pending-write counters with issue/retire update and
// write-through-aware busy lookups for the two ID source registers.
module hazard_scoreboard_unit_scoreboard #(
    parameter int REG_ADDR_W = 2,
    parameter int SB_CNT_W   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  issue,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic                  retire,
    input  logic [REG_ADDR_W-1:0] retire_dest,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  busy_rs,
    output logic                  busy_rt
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam logic [SB_CNT_W-1:0] CNT_MAX = {SB_CNT_W{1'b1}};
    localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

    logic [SB_CNT_W-1:0] cnt_q [NUM_REGS];
    logic [SB_CNT_W-1:0] cnt_d [NUM_REGS];

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue && (issue_dest == REG_ADDR_W'(r)) &&
                !(retire && (retire_dest == REG_ADDR_W'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (retire && (retire_dest == REG_ADDR_W'(r)) &&
                         !(issue && (issue_dest == REG_ADDR_W'(r)))) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!reset_n) begin
                cnt_q[r] <= '0;
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Counter over/underflow means the pipeline issued or retired inconsistently.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (issue && !(retire && (retire_dest == issue_dest)) &&
                (cnt_q[issue_dest] == CNT_MAX)) begin
                $error("hcu scoreboard: increment at max for reg %0d", issue_dest);
            end
            if (retire && !(issue && (issue_dest == retire_dest)) &&
                (cnt_q[retire_dest] == '0)) begin
                $error("hcu scoreboard: decrement at zero for reg %0d", retire_dest);
            end
        end
    end

    // A single pending write retiring this cycle is visible through the regfile.
    assign busy_rs = (cnt_q[rs] != '0) &&
                     !((cnt_q[rs] == CNT_ONE) && retire && (retire_dest == rs));
    assign busy_rt = (cnt_q[rt] != '0) &&
                     !((cnt_q[rt] == CNT_ONE) && retire && (retire_dest == rt));

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard-based hazard controller for the five-stage TSC pipeline.
// Optional performance counters are enabled by defining HCU_PERF_CNT_EN.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int REG_ADDR_W      = 2,
    parameter int DATA_FORWARDING = 1,
    parameter int SB_CNT_W        = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            opcode_ID,
    input  logic [5:0]            func_code_ID,
    input  logic                  valid_ID,
    input  logic [REG_ADDR_W-1:0] rs_ID,
    input  logic [REG_ADDR_W-1:0] rt_ID,
    input  logic                  reg_write_ID,
    input  logic [REG_ADDR_W-1:0] dest_ID,
    input  logic                  d_mem_read_EX,
    input  logic [REG_ADDR_W-1:0] dest_EX,
    input  logic                  reg_write_WB,
    input  logic [REG_ADDR_W-1:0] dest_WB,
    input  logic                  halt_WB,
    input  logic                  i_branch_miss,
    input  logic                  jump_miss,
    input  logic                  i_mem_ready,
    input  logic                  d_mem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  flush_IFID,
    output logic                  flush_IDEX,
    output logic                  freeze_all,
    output logic                  halted
`ifdef HCU_PERF_CNT_EN
    ,
    output logic [15:0]           stall_cycles,
    output logic [15:0]           flush_cycles,
    output logic [15:0]           freeze_cycles
`endif
);

    localparam bit FWD_EN = (DATA_FORWARDING != 0);

    hcu_state_e state_q, state_d;
    hcu_cause_e cause;
    hcu_ctrl_t  ctrl;

    logic freeze_cond;
    logic retire;
    logic issue;
    logic busy_rs, busy_rt;
    logic hz_rs, hz_rt;
    logic data_stall;

    // Kept separate from the priority chain so retire does not loop through it.
    assign freeze_cond = reset_n && ((state_q == HCU_S_HALT) || !d_mem_ready);
    assign retire      = reg_write_WB && !freeze_cond;

    hazard_scoreboard_unit_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .SB_CNT_W   (SB_CNT_W)
    ) u_scoreboard (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue       (issue),
        .issue_dest  (dest_ID),
        .retire      (retire),
        .retire_dest (dest_WB),
        .rs          (rs_ID),
        .rt          (rt_ID),
        .busy_rs     (busy_rs),
        .busy_rt     (busy_rt)
    );

    assign hz_rs = FWD_EN ? (d_mem_read_EX && (dest_EX == rs_ID)) : busy_rs;
    assign hz_rt = FWD_EN ? (d_mem_read_EX && (dest_EX == rt_ID)) : busy_rt;
    assign data_stall = valid_ID &&
                        ((uses_rs(opcode_ID, func_code_ID) && hz_rs) ||
                         (uses_rt(opcode_ID, func_code_ID) && hz_rt));

    always_comb begin
        cause = HCU_C_NONE;
        if (!reset_n) begin
            cause = HCU_C_RESET;
        end else if (state_q == HCU_S_HALT) begin
            cause = HCU_C_HALT;
        end else if (!d_mem_ready) begin
            cause = HCU_C_DFREEZE;
        end else if (i_branch_miss) begin
            cause = HCU_C_BMISS;
        end else if (jump_miss) begin
            cause = HCU_C_JMISS;
        end else if (data_stall) begin
            cause = HCU_C_DSTALL;
        end else if (!i_mem_ready) begin
            cause = HCU_C_IFETCH;
        end
    end

    always_comb begin
        ctrl = '{pc_write: 1'b1, ir_write: 1'b1, default: 1'b0};
        case (cause)
            HCU_C_RESET:   ctrl = '{flush_ifid: 1'b1, flush_idex: 1'b1, default: 1'b0};
            HCU_C_HALT:    ctrl = '{freeze_all: 1'b1, halted: 1'b1, default: 1'b0};
            HCU_C_DFREEZE: ctrl = '{freeze_all: 1'b1, default: 1'b0};
            HCU_C_BMISS:   ctrl = '{pc_write: 1'b1, ir_write: 1'b1, flush_ifid: 1'b1,
                                    flush_idex: 1'b1, default: 1'b0};
            HCU_C_JMISS:   ctrl = '{pc_write: 1'b1, ir_write: 1'b1, flush_ifid: 1'b1,
                                    default: 1'b0};
            HCU_C_DSTALL:  ctrl = '{flush_idex: 1'b1, default: 1'b0};
            HCU_C_IFETCH:  ctrl = '{ir_write: 1'b1, flush_ifid: 1'b1, default: 1'b0};
            default:       ctrl = '{pc_write: 1'b1, ir_write: 1'b1, default: 1'b0};
        endcase
    end

    assign pc_write   = ctrl.pc_write;
    assign ir_write   = ctrl.ir_write;
    assign flush_IFID = ctrl.flush_ifid;
    assign flush_IDEX = ctrl.flush_idex;
    assign freeze_all = ctrl.freeze_all;
    assign halted     = ctrl.halted;

    // The ID instruction leaves for EX unless it is bubbled or the pipe is held.
    assign issue = valid_ID && reg_write_ID && !ctrl.freeze_all && !ctrl.flush_idex;

    always_comb begin
        state_d = state_q;
        case (state_q)
            HCU_S_RUN:   if (!d_mem_ready) state_d = HCU_S_DWAIT;
            HCU_S_DWAIT: if (d_mem_ready) state_d = HCU_S_RUN;
            HCU_S_HALT:  state_d = HCU_S_HALT;
            default:     state_d = HCU_S_RUN;
        endcase
        if (halt_WB && !freeze_cond) begin
            state_d = HCU_S_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= HCU_S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HCU_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] freeze_cnt_q, freeze_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if ((cause == HCU_C_DSTALL) || (cause == HCU_C_IFETCH)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if ((cause == HCU_C_BMISS) || (cause == HCU_C_JMISS)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
        if (cause == HCU_C_DFREEZE) begin
            freeze_cnt_d = freeze_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign flush_cycles  = flush_cnt_q;
    assign freeze_cycles = freeze_cnt_q;
`endif

endmodule
